// File: rtl/demux_rr_scheduler.sv
// Round-robin sequencing controller for a 1x8 demux: accepts one word, picks an enabled channel, holds it until accepted.
// Optional STALL_TIMEOUT_EN: drop the held word after TIMEOUT stalled SEND cycles.
module demux_rr_scheduler #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    en_mask,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [7:0]    ch_ready,
  output logic [7:0]    out_valid,
  output logic [DW-1:0] out_data,
  output logic [2:0]    sel,
  output logic [15:0]   xfer_cnt,
  output logic          drop
);

  typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic       grant_found;
  logic [2:0] grant;
  logic [2:0] idx;
  logic       sel_ready;
  logic       timeout_hit;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("demux_rr_scheduler: TIMEOUT must be in 1..255");
  end

  assign in_ready  = (state == IDLE);
  assign sel_ready = ch_ready[sel];

  // Scan from the farthest offset down so the channel closest to ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant       = ptr;
    idx         = ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (en_mask[idx]) begin
        grant_found = 1'b1;
        grant       = idx;
      end
    end
  end

`ifdef STALL_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

  // Counter restarts every time SEND is entered; drop is a registered one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      drop     <= 1'b0;
    end else begin
      drop <= (state == SEND) && !sel_ready && timeout_hit;
      if (state != SEND) begin
        wait_cnt <= '0;
      end else if (!sel_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign drop        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      out_valid <= '0;
      out_data  <= '0;
      xfer_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_data <= in_data;
            state    <= ARB;
          end
        end
        ARB: begin
          if (grant_found) begin
            sel       <= grant;
            out_valid <= 8'b1 << grant;
            state     <= SEND;
          end
        end
        SEND: begin
          // A transfer on the same edge as the timeout takes precedence.
          if (sel_ready) begin
            out_valid <= '0;
            ptr       <= sel + 3'd1;
            xfer_cnt  <= xfer_cnt + 16'd1;
            state     <= IDLE;
          end else if (timeout_hit) begin
            out_valid <= '0;
            ptr       <= sel + 3'd1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Self-checking bench for demux_rr_scheduler: directed and randomized words against a round-robin reference model.
module tb_demux_rr_scheduler;

  localparam int DW = 8;
  localparam int TO = 4;
`ifdef STALL_TIMEOUT_EN
  localparam int MAXSTALL = TO - 1;
`else
  localparam int MAXSTALL = 10;
`endif

  logic          clk;
  logic          rst_n;
  logic [7:0]    en_mask;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [7:0]    ch_ready;
  logic [7:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    sel;
  logic [15:0]   xfer_cnt;
  logic          drop;

  int checks;
  int failures;
  int mPtr;
  int mCnt;

  demux_rr_scheduler #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_mask(en_mask),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .ch_ready(ch_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .sel(sel),
    .xfer_cnt(xfer_cnt),
    .drop(drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first enabled channel at or after the pointer, cyclically.
  function automatic int refGrant(input int p, input logic [7:0] m);
    for (int k = 0; k < 8; k++) begin
      if (m[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [7:0] data, input logic [7:0] mask, input int arbHold,
                               input int stall, input logic [7:0] otherReady);
    int g;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    en_mask  = (arbHold > 0) ? 8'h00 : mask;
    in_valid = 1'b1;
    in_data  = data;
    ch_ready = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    checkOutput("arb_in_ready", 32'(in_ready), 32'd0);
    checkOutput("arb_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < arbHold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd0);
    end
    en_mask = mask;
    g = refGrant(mPtr, mask);
    @(posedge clk); #1;
    checkOutput("grant_sel", 32'(sel), 32'(g));
    checkOutput("grant_out_valid", 32'(out_valid), 32'(1) << g);
    checkOutput("grant_out_data", 32'(out_data), 32'(data));
    for (int i = 0; i < stall; i++) begin
      ch_ready = otherReady & ~(8'b1 << g);
      en_mask  = 8'($urandom);
      @(posedge clk); #1;
      checkOutput("stall_out_valid", 32'(out_valid), 32'(1) << g);
      checkOutput("stall_sel", 32'(sel), 32'(g));
      checkOutput("stall_out_data", 32'(out_data), 32'(data));
      checkOutput("stall_drop", 32'(drop), 32'd0);
    end
    ch_ready = otherReady | (8'b1 << g);
    @(posedge clk); #1;
    mCnt = mCnt + 1;
    mPtr = (g + 1) % 8;
    ch_ready = 8'h00;
    checkOutput("done_out_valid", 32'(out_valid), 32'd0);
    checkOutput("done_xfer_cnt", 32'(xfer_cnt), 32'(mCnt % 65536));
    checkOutput("done_in_ready", 32'(in_ready), 32'd1);
    checkOutput("done_drop", 32'(drop), 32'd0);
  endtask

  initial begin
    int g;
    checks   = 0;
    failures = 0;
    mPtr     = 0;
    mCnt     = 0;
    rst_n    = 1'b0;
    en_mask  = 8'h00;
    in_valid = 1'b0;
    in_data  = '0;
    ch_ready = 8'h00;

    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sel", 32'(sel), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    checkOutput("rst_drop", 32'(drop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] full mask, back-to-back words 0x11..0x99");
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i * 8'h11), 8'hFF, 0, 0, 8'hFF);
    checkOutput("nine_xfers", 32'(xfer_cnt), 32'd9);

    $display("[TB] sparse mask 1010_0100");
    for (int i = 0; i < 5; i++) applyStimulus(8'($urandom), 8'b1010_0100, 0, 0, 8'hFF);

    $display("[TB] empty mask hold, then channel 4");
    applyStimulus(8'h3C, 8'h10, 3, 0, 8'hFF);

    $display("[TB] stall on channel 3");
    applyStimulus(8'hC3, 8'h08, 0, MAXSTALL, 8'hFF);

    $display("[TB] randomized words");
    for (int i = 0; i < 25; i++) begin
      applyStimulus(8'($urandom), 8'($urandom_range(1, 255)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, MAXSTALL)), 8'($urandom));
    end

`ifdef STALL_TIMEOUT_EN
    $display("[TB] stall timeout drop");
    @(negedge clk);
    en_mask  = 8'($urandom_range(1, 255));
    in_valid = 1'b1;
    in_data  = 8'hE7;
    ch_ready = 8'h00;
    g = refGrant(mPtr, en_mask);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("to_grant_sel", 32'(sel), 32'(g));
    for (int i = 0; i < TO - 1; i++) begin
      @(posedge clk); #1;
      checkOutput("to_wait_drop", 32'(drop), 32'd0);
      checkOutput("to_wait_out_valid", 32'(out_valid), 32'(1) << g);
    end
    @(posedge clk); #1;
    checkOutput("to_drop_pulse", 32'(drop), 32'd1);
    checkOutput("to_out_valid", 32'(out_valid), 32'd0);
    checkOutput("to_xfer_cnt", 32'(xfer_cnt), 32'(mCnt % 65536));
    checkOutput("to_in_ready", 32'(in_ready), 32'd1);
    mPtr = (g + 1) % 8;
    @(posedge clk); #1;
    checkOutput("to_drop_clear", 32'(drop), 32'd0);
    applyStimulus(8'h42, 8'hFF, 0, 0, 8'hFF);
`else
    $display("[TB] long stall without timeout");
    applyStimulus(8'h42, 8'hFF, 0, 20, 8'h00);
`endif

    $display("[TB] reset during SEND");
    applyStimulus(8'h77, 8'h10, 0, 0, 8'hFF);
    @(negedge clk);
    en_mask  = 8'hFF;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    ch_ready = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre_rst_sel", 32'(sel), 32'd5);
    checkOutput("pre_rst_out_valid", 32'(out_valid), 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_sel", 32'(sel), 32'd0);
    checkOutput("async_rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    checkOutput("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mPtr  = 0;
    mCnt  = 0;
    applyStimulus(8'hA5, 8'hFF, 0, 0, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
